ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//   EX/MEM pipeline register of the 5-stage RV32 pipeline. Captures the execute-stage results
//   (branch target, PC+4, ALU result, zero flag, store data) plus the MEM/WB control bundle.
//   Resolves the branch/jump decision from the registered values for the fetch stage.
//   Supports stall (hold), flush (bubble insert) and a valid bit that gates side effects.
// PARAMETERS
//   XLEN   32  datapath width (PC, ALU result, store data)
//   RD_W   5   destination register index width
// PORTS
//   clk              in   1     pipeline clock, all state updates on rising edge
//   rst              in   1     synchronous, active-high reset
//   stall_in         in   1     hazard unit: hold current contents
//   flush_in         in   1     hazard unit: load a bubble
//   valid_in_EXMEM   in   1     EX stage holds a real instruction
//   PC_in_EXMEM      in   XLEN  branch target PC+imm from EX
//   PC4_in_EXMEM     in   XLEN  PC+4 from EX
//   ALU_in_EXMEM     in   XLEN  ALU result from EX
//   zero_in_EXMEM    in   1     ALU zero flag from EX
//   Rs2_in_EXMEM     in   XLEN  store data from EX
//   rd_in_EXMEM      in   RD_W  destination register
//   RegWrite_in      in   1     write-back enable
//   MemRW_in         in   1     1 = store, 0 = load/none
//   MemtoReg_in      in   2     WB select: 00 ALU, 01 mem, 10 PC+4
//   Branch_in        in   1     conditional branch (beq)
//   Jump_in          in   2     00 none, 01 jal, 10 jalr
//   valid_out        out  1     MEM stage instruction is real
//   PC4_out / ALU_out / Rs2_out  out XLEN  registered copies
//   rd_out           out  RD_W  registered destination register
//   RegWrite_out     out  1     registered RegWrite AND valid
//   MemRW_out        out  1     registered MemRW AND valid
//   MemtoReg_out     out  2     registered WB select
//   PCSrc_out        out  1     redirect fetch (combinational from registers)
//   PC_target_out    out  XLEN  redirect address
// BEHAVIOUR
//   - Reset: every register 0; valid_out=0, PCSrc_out=0, PC_target_out=0.
//   - Priority each edge: rst > flush_in > stall_in > load.
//   - flush_in: valid <=0, RegWrite/MemRW/Branch/Jump regs <=0; data regs may keep old value.
//   - stall_in (no flush): all registers hold; outputs stable.
//   - load: all fields captured from *_in; latency 1 cycle EX->MEM.
//   - valid_in_EXMEM=0 on load behaves as flush (bubble propagated).
//   - RegWrite_out, MemRW_out forced 0 whenever valid_out=0 (no stray store/writeback).
//   - PCSrc_out = valid & ((Branch & zero) | Jump!=00).
//   - PC_target_out: jalr -> {ALU[XLEN-1:1],1'b0}; jal/branch -> registered PC; else 0.
//   - Jump=11 reserved: treated as 00 (no redirect).
//   - flush_in and stall_in together: flush wins. rst mid-stall: clears on that edge.
//   - Hazard unit must flush this register the cycle after PCSrc_out=1 taken in its own
//     younger stages; this block never self-flushes.
// CONFIGURATION
//   EXMEM_PERF_CNT_EN defined: adds outputs bubble_cnt_out[31:0], redirect_cnt_out[31:0];
//     bubble_cnt increments each non-stalled edge that loads valid=0; redirect_cnt each
//     edge where PCSrc_out=1 and stall_in=0; both wrap 0xFFFFFFFF->0, cleared by rst,
//     frozen while stall_in=1.
//   Undefined: ports and counters absent; no other behaviour difference.
// TESTING
//   1 rst=1 two edges, inputs all 1s -> all outputs 0, PCSrc_out=0.
//   2 load ALU=0x00001234,rd=5,RegWrite=1,valid=1 -> next cycle ALU_out=0x1234,rd_out=5,RegWrite_out=1.
//   3 Branch=1,zero=1,PC_in=0x00000040 -> PCSrc_out=1,PC_target_out=0x40; zero=0 -> PCSrc_out=0.
//   4 jalr ALU_in=0x00000103 -> PC_target_out=0x00000102, PCSrc_out=1, PC4_out passed through.
//   5 MemRW=1 loaded, then stall 3 cycles -> outputs unchanged; flush+stall together -> valid_out=0,MemRW_out=0.
//   6 EXMEM_PERF_CNT_EN: 3 bubbles + 2 redirects, 1 stalled cycle -> bubble_cnt=3, redirect_cnt=2.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline register bus: EX-stage results, hazard controls and MEM-stage outputs.
// Performance counter outputs exist only when EXMEM_PERF_CNT_EN is defined.
interface ex_mem_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            stall_in;
    logic            flush_in;
    logic            valid_in_EXMEM;
    logic [XLEN-1:0] PC_in_EXMEM;
    logic [XLEN-1:0] PC4_in_EXMEM;
    logic [XLEN-1:0] ALU_in_EXMEM;
    logic            zero_in_EXMEM;
    logic [XLEN-1:0] Rs2_in_EXMEM;
    logic [RD_W-1:0] rd_in_EXMEM;
    logic            RegWrite_in;
    logic            MemRW_in;
    logic [1:0]      MemtoReg_in;
    logic            Branch_in;
    logic [1:0]      Jump_in;

    logic            valid_out;
    logic [XLEN-1:0] PC4_out;
    logic [XLEN-1:0] ALU_out;
    logic [XLEN-1:0] Rs2_out;
    logic [RD_W-1:0] rd_out;
    logic            RegWrite_out;
    logic            MemRW_out;
    logic [1:0]      MemtoReg_out;
    logic            PCSrc_out;
    logic [XLEN-1:0] PC_target_out;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0]     bubble_cnt_out;
    logic [31:0]     redirect_cnt_out;
`endif

    modport slave (
        input  stall_in, flush_in, valid_in_EXMEM, PC_in_EXMEM, PC4_in_EXMEM,
               ALU_in_EXMEM, zero_in_EXMEM, Rs2_in_EXMEM, rd_in_EXMEM,
               RegWrite_in, MemRW_in, MemtoReg_in, Branch_in, Jump_in,
        output valid_out, PC4_out, ALU_out, Rs2_out, rd_out, RegWrite_out,
               MemRW_out, MemtoReg_out, PCSrc_out, PC_target_out
`ifdef EXMEM_PERF_CNT_EN
             , bubble_cnt_out, redirect_cnt_out
`endif
    );

    modport master (
        output stall_in, flush_in, valid_in_EXMEM, PC_in_EXMEM, PC4_in_EXMEM,
               ALU_in_EXMEM, zero_in_EXMEM, Rs2_in_EXMEM, rd_in_EXMEM,
               RegWrite_in, MemRW_in, MemtoReg_in, Branch_in, Jump_in,
        input  valid_out, PC4_out, ALU_out, Rs2_out, rd_out, RegWrite_out,
               MemRW_out, MemtoReg_out, PCSrc_out, PC_target_out
`ifdef EXMEM_PERF_CNT_EN
             , bubble_cnt_out, redirect_cnt_out
`endif
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, valid-gated side effects and branch/jump redirect.
// Define EXMEM_PERF_CNT_EN to add bubble and redirect event counters.
module ex_mem_reg #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    ex_mem_if.slave    bus
);
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc4_r;
    logic [XLEN-1:0] alu_r;
    logic            zero_r;
    logic [XLEN-1:0] rs2_r;
    logic [RD_W-1:0] rd_r;
    logic            reg_write_r;
    logic            mem_rw_r;
    logic [1:0]      mem_to_reg_r;
    logic            branch_r;
    logic [1:0]      jump_r;

    logic            bubble_s;
    logic            pcsrc_s;
    logic [XLEN-1:0] target_s;

    // Reserved jump encoding 2'b11 never redirects.
    function automatic logic redirect_f(input logic valid, input logic branch,
                                        input logic zero, input logic [1:0] jump);
        return valid & ((branch & zero) | (jump == JUMP_JAL) | (jump == JUMP_JALR));
    endfunction

    // A flush, or loading an invalid EX slot, inserts a bubble.
    always_comb begin
        bubble_s = bus.flush_in | ~bus.valid_in_EXMEM;
    end

    // Pipeline state: rst > flush > stall > load; bubbles clear control, data may hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r      <= 1'b0;
            pc_r         <= {XLEN{1'b0}};
            pc4_r        <= {XLEN{1'b0}};
            alu_r        <= {XLEN{1'b0}};
            zero_r       <= 1'b0;
            rs2_r        <= {XLEN{1'b0}};
            rd_r         <= {RD_W{1'b0}};
            reg_write_r  <= 1'b0;
            mem_rw_r     <= 1'b0;
            mem_to_reg_r <= 2'b00;
            branch_r     <= 1'b0;
            jump_r       <= 2'b00;
        end else if (bus.flush_in || (!bus.stall_in && bubble_s)) begin
            valid_r      <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_rw_r     <= 1'b0;
            branch_r     <= 1'b0;
            jump_r       <= 2'b00;
        end else if (!bus.stall_in) begin
            valid_r      <= 1'b1;
            pc_r         <= bus.PC_in_EXMEM;
            pc4_r        <= bus.PC4_in_EXMEM;
            alu_r        <= bus.ALU_in_EXMEM;
            zero_r       <= bus.zero_in_EXMEM;
            rs2_r        <= bus.Rs2_in_EXMEM;
            rd_r         <= bus.rd_in_EXMEM;
            reg_write_r  <= bus.RegWrite_in;
            mem_rw_r     <= bus.MemRW_in;
            mem_to_reg_r <= bus.MemtoReg_in;
            branch_r     <= bus.Branch_in;
            jump_r       <= bus.Jump_in;
        end else begin
            valid_r      <= valid_r;
        end
    end

    // Redirect decision and address, derived only from registered state.
    always_comb begin
        pcsrc_s  = redirect_f(valid_r, branch_r, zero_r, jump_r);
        target_s = {XLEN{1'b0}};
        case (jump_r)
            JUMP_JALR: target_s = {alu_r[XLEN-1:1], 1'b0};
            JUMP_JAL:  target_s = pc_r;
            default: begin
                if (branch_r) begin
                    target_s = pc_r;
                end else begin
                    target_s = {XLEN{1'b0}};
                end
            end
        endcase
    end

    // Output drive; side-effect enables are masked by valid.
    always_comb begin
        bus.valid_out     = valid_r;
        bus.PC4_out       = pc4_r;
        bus.ALU_out       = alu_r;
        bus.Rs2_out       = rs2_r;
        bus.rd_out        = rd_r;
        bus.RegWrite_out  = reg_write_r & valid_r;
        bus.MemRW_out     = mem_rw_r & valid_r;
        bus.MemtoReg_out  = mem_to_reg_r;
        bus.PCSrc_out     = pcsrc_s;
        bus.PC_target_out = target_s;
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Event counters; frozen while stalled, wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r   <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else if (!bus.stall_in) begin
            if (bubble_s) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (pcsrc_s) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
        end else begin
            bubble_cnt_r   <= bubble_cnt_r;
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    // Counter output drive.
    always_comb begin
        bus.bubble_cnt_out   = bubble_cnt_r;
        bus.redirect_cnt_out = redirect_cnt_r;
    end
`endif
endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_ex_mem_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_mem_if #(.XLEN(32), .RD_W(5)) bus ();

    ex_mem_reg #(.XLEN(32), .RD_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] pc, pc4, alu, rs2;
        logic        zero;
        logic [4:0]  rd;
        logic        rw, mrw;
        logic [1:0]  m2r;
        logic        br;
        logic [1:0]  jmp;
    } in_t;

    typedef struct {
        string       name;
        logic        chk_data;
        logic        valid;
        logic [31:0] pc4, alu, rs2;
        logic [4:0]  rd;
        logic        rw, mrw;
        logic [1:0]  m2r;
        logic        pcsrc;
        logic [31:0] tgt;
        logic [31:0] bub, red;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic in_t nop_in();
        in_t v;
        v.rst = 1'b0; v.stall = 1'b0; v.flush = 1'b0; v.valid = 1'b1;
        v.pc = 32'd0; v.pc4 = 32'd0; v.alu = 32'd0; v.rs2 = 32'd0;
        v.zero = 1'b0; v.rd = 5'd0; v.rw = 1'b0; v.mrw = 1'b0;
        v.m2r = 2'b00; v.br = 1'b0; v.jmp = 2'b00;
        return v;
    endfunction

    function automatic exp_t zero_exp(input string name, input logic [31:0] bub,
                                      input logic [31:0] red);
        exp_t e;
        e.name = name; e.chk_data = 1'b1; e.valid = 1'b0;
        e.pc4 = 32'd0; e.alu = 32'd0; e.rs2 = 32'd0; e.rd = 5'd0;
        e.rw = 1'b0; e.mrw = 1'b0; e.m2r = 2'b00; e.pcsrc = 1'b0; e.tgt = 32'd0;
        e.bub = bub; e.red = red;
        return e;
    endfunction

    function automatic exp_t bubble_exp(input string name, input logic [31:0] bub,
                                        input logic [31:0] red);
        exp_t e;
        e = zero_exp(name, bub, red);
        e.chk_data = 1'b0;
        return e;
    endfunction

    task automatic apply(input in_t v, input exp_t e);
        @(negedge clk);
        rst                    = v.rst;
        bus.stall_in           = v.stall;
        bus.flush_in           = v.flush;
        bus.valid_in_EXMEM     = v.valid;
        bus.PC_in_EXMEM        = v.pc;
        bus.PC4_in_EXMEM       = v.pc4;
        bus.ALU_in_EXMEM       = v.alu;
        bus.zero_in_EXMEM      = v.zero;
        bus.Rs2_in_EXMEM       = v.rs2;
        bus.rd_in_EXMEM        = v.rd;
        bus.RegWrite_in        = v.rw;
        bus.MemRW_in           = v.mrw;
        bus.MemtoReg_in        = v.m2r;
        bus.Branch_in          = v.br;
        bus.Jump_in            = v.jmp;
        q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got 0x%08h expected 0x%08h", tag, field, act, req);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "valid_out",     {31'd0, bus.valid_out},    {31'd0, e.valid});
                cmp(e.name, "RegWrite_out",  {31'd0, bus.RegWrite_out}, {31'd0, e.rw});
                cmp(e.name, "MemRW_out",     {31'd0, bus.MemRW_out},    {31'd0, e.mrw});
                cmp(e.name, "PCSrc_out",     {31'd0, bus.PCSrc_out},    {31'd0, e.pcsrc});
                cmp(e.name, "PC_target_out", bus.PC_target_out,         e.tgt);
                if (e.chk_data) begin
                    cmp(e.name, "PC4_out",      bus.PC4_out,               e.pc4);
                    cmp(e.name, "ALU_out",      bus.ALU_out,               e.alu);
                    cmp(e.name, "Rs2_out",      bus.Rs2_out,               e.rs2);
                    cmp(e.name, "rd_out",       {27'd0, bus.rd_out},       {27'd0, e.rd});
                    cmp(e.name, "MemtoReg_out", {30'd0, bus.MemtoReg_out}, {30'd0, e.m2r});
                end
`ifdef EXMEM_PERF_CNT_EN
                cmp(e.name, "bubble_cnt",   bus.bubble_cnt_out,   e.bub);
                cmp(e.name, "redirect_cnt", bus.redirect_cnt_out, e.red);
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        in_t  v;
        exp_t e;
        v = nop_in();
        rst = 1'b1;
        bus.stall_in = 1'b0; bus.flush_in = 1'b0; bus.valid_in_EXMEM = 1'b0;
        bus.PC_in_EXMEM = 32'd0; bus.PC4_in_EXMEM = 32'd0; bus.ALU_in_EXMEM = 32'd0;
        bus.zero_in_EXMEM = 1'b0; bus.Rs2_in_EXMEM = 32'd0; bus.rd_in_EXMEM = 5'd0;
        bus.RegWrite_in = 1'b0; bus.MemRW_in = 1'b0; bus.MemtoReg_in = 2'b00;
        bus.Branch_in = 1'b0; bus.Jump_in = 2'b00;

        // Reset with every input high, two edges
        v.rst = 1'b1; v.stall = 1'b1; v.flush = 1'b1; v.valid = 1'b1;
        v.pc = 32'hFFFF_FFFF; v.pc4 = 32'hFFFF_FFFF; v.alu = 32'hFFFF_FFFF;
        v.rs2 = 32'hFFFF_FFFF; v.zero = 1'b1; v.rd = 5'h1F; v.rw = 1'b1;
        v.mrw = 1'b1; v.m2r = 2'b11; v.br = 1'b1; v.jmp = 2'b11;
        apply(v, zero_exp("reset1", 32'd0, 32'd0));
        apply(v, zero_exp("reset2", 32'd0, 32'd0));

        // ALU writeback load
        v = nop_in(); v.alu = 32'h0000_1234; v.rd = 5'd5; v.rw = 1'b1;
        e = zero_exp("alu_load", 32'd0, 32'd0);
        e.valid = 1'b1; e.alu = 32'h0000_1234; e.rd = 5'd5; e.rw = 1'b1;
        apply(v, e);

        // Taken beq
        v = nop_in(); v.br = 1'b1; v.zero = 1'b1; v.pc = 32'h0000_0040; v.pc4 = 32'h0000_0044;
        e = zero_exp("beq_taken", 32'd0, 32'd0);
        e.valid = 1'b1; e.pc4 = 32'h0000_0044; e.pcsrc = 1'b1; e.tgt = 32'h0000_0040;
        apply(v, e);

        // Not-taken beq: target still the registered PC, no redirect
        v = nop_in(); v.br = 1'b1; v.zero = 1'b0; v.pc = 32'h0000_0080;
        e = zero_exp("beq_not_taken", 32'd0, 32'd1);
        e.valid = 1'b1; e.tgt = 32'h0000_0080;
        apply(v, e);

        // jalr: LSB of target cleared
        v = nop_in(); v.jmp = 2'b10; v.alu = 32'h0000_0103; v.pc4 = 32'h0000_0108;
        v.pc = 32'h0000_0200; v.rd = 5'd1; v.rw = 1'b1; v.m2r = 2'b10;
        e = zero_exp("jalr", 32'd0, 32'd1);
        e.valid = 1'b1; e.alu = 32'h0000_0103; e.pc4 = 32'h0000_0108; e.rd = 5'd1;
        e.rw = 1'b1; e.m2r = 2'b10; e.pcsrc = 1'b1; e.tgt = 32'h0000_0102;
        apply(v, e);

        // Store
        v = nop_in(); v.mrw = 1'b1; v.alu = 32'h0000_1000; v.rs2 = 32'hDEAD_BEEF;
        v.pc4 = 32'h0000_010C;
        e = zero_exp("store", 32'd0, 32'd2);
        e.valid = 1'b1; e.mrw = 1'b1; e.alu = 32'h0000_1000; e.rs2 = 32'hDEAD_BEEF;
        e.pc4 = 32'h0000_010C;
        apply(v, e);

        // Three stalled cycles with different inputs: outputs hold the store
        for (int i = 0; i < 3; i++) begin
            v = nop_in(); v.stall = 1'b1; v.alu = 32'h0000_FFFF; v.rw = 1'b1;
            v.jmp = 2'b01; v.pc = 32'h0000_0999;
            e.name = $sformatf("stall%0d", i);
            apply(v, e);
        end

        // Flush and stall together: flush wins, counters frozen
        v = nop_in(); v.stall = 1'b1; v.flush = 1'b1; v.mrw = 1'b1; v.rw = 1'b1;
        apply(v, bubble_exp("flush_stall", 32'd0, 32'd2));

        // Invalid EX slot with all controls set behaves as a flush
        v = nop_in(); v.valid = 1'b0; v.rw = 1'b1; v.mrw = 1'b1; v.br = 1'b1;
        v.zero = 1'b1; v.jmp = 2'b01; v.pc = 32'h0000_0777;
        apply(v, bubble_exp("invalid_load", 32'd1, 32'd2));

        // Plain flush of a valid instruction
        v = nop_in(); v.flush = 1'b1; v.rw = 1'b1; v.jmp = 2'b10;
        apply(v, bubble_exp("flush", 32'd2, 32'd2));

        // jal
        v = nop_in(); v.jmp = 2'b01; v.pc = 32'h0000_0300; v.pc4 = 32'h0000_0304;
        v.alu = 32'h0000_0055; v.rd = 5'd1; v.rw = 1'b1; v.m2r = 2'b10;
        e = zero_exp("jal", 32'd2, 32'd2);
        e.valid = 1'b1; e.pc4 = 32'h0000_0304; e.alu = 32'h0000_0055; e.rd = 5'd1;
        e.rw = 1'b1; e.m2r = 2'b10; e.pcsrc = 1'b1; e.tgt = 32'h0000_0300;
        apply(v, e);

        // Reserved jump encoding: no redirect, target 0
        v = nop_in(); v.jmp = 2'b11; v.pc = 32'h0000_0500; v.alu = 32'h0000_0501;
        v.rw = 1'b1; v.rd = 5'd7;
        e = zero_exp("jump_reserved", 32'd2, 32'd3);
        e.valid = 1'b1; e.alu = 32'h0000_0501; e.rw = 1'b1; e.rd = 5'd7;
        apply(v, e);

        // Reset during a stall clears everything
        v = nop_in(); v.rst = 1'b1; v.stall = 1'b1;
        apply(v, zero_exp("reset_in_stall", 32'd0, 32'd0));

        // Counter scenario: 3 bubbles, one stalled cycle, 2 redirects
        v = nop_in(); v.valid = 1'b0;
        apply(v, bubble_exp("cnt_bubble1", 32'd1, 32'd0));
        v = nop_in(); v.valid = 1'b0; v.stall = 1'b1;
        apply(v, bubble_exp("cnt_stall", 32'd1, 32'd0));
        v = nop_in(); v.valid = 1'b0;
        apply(v, bubble_exp("cnt_bubble2", 32'd2, 32'd0));
        v = nop_in(); v.flush = 1'b1;
        apply(v, bubble_exp("cnt_bubble3", 32'd3, 32'd0));

        v = nop_in(); v.jmp = 2'b01; v.pc = 32'h0000_0400;
        e = zero_exp("cnt_jal1", 32'd3, 32'd0);
        e.valid = 1'b1; e.pcsrc = 1'b1; e.tgt = 32'h0000_0400;
        apply(v, e);
        v = nop_in(); v.jmp = 2'b01; v.pc = 32'h0000_0500;
        e = zero_exp("cnt_jal2", 32'd3, 32'd1);
        e.valid = 1'b1; e.pcsrc = 1'b1; e.tgt = 32'h0000_0500;
        apply(v, e);
        v = nop_in();
        e = zero_exp("cnt_nop", 32'd3, 32'd2);
        e.valid = 1'b1;
        apply(v, e);

        // Drain: every expectation must have been consumed
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
